// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit: FSM states,
// RISC-V load/store funct3 encodings, access-size decode and byte-lane masks.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 4'd1;
      F3_H, F3_HU: return 4'd2;
      F3_W, F3_WU: return 4'd4;
      default:     return 4'd8;
    endcase
  endfunction

  // Lanes touched across two consecutive words: bits [B-1:0] are the first
  // beat, bits [2B-1:B] the spill-over into the next word.
  function automatic logic [15:0] byte_mask(input logic [2:0] off, input logic [3:0] size);
    logic [15:0] m;
    m = (16'h0001 << size) - 16'h0001;
    return m << off;
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3, input logic store,
                                      input logic xlen64);
    return (f3 == 3'b111) || (store && f3[2]) ||
           (!xlen64 && ((f3 == F3_D) || (f3 == F3_WU)));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane shifter over a two-word window. Left shift places store data onto
// bus lanes; right shift gathers load bytes and sign/zero-extends the result.
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]           data_i,
  input  logic [$clog2(XLEN/8)-1:0]   off_i,
  input  logic                        shl_i,
  input  logic [3:0]                  size_i,
  input  logic                        unsigned_i,
  output logic [2*XLEN-1:0]           data_o
);

  logic [2*XLEN-1:0] shifted;
  logic [XLEN-1:0]   low;
  logic [XLEN-1:0]   ext;
  logic              sign;

  always_comb begin
    shifted = shl_i ? (data_i << {off_i, 3'b000}) : (data_i >> {off_i, 3'b000});
    low     = shifted[XLEN-1:0];
    case (size_i)
      4'd1:    sign = low[7];
      4'd2:    sign = low[15];
      4'd4:    sign = low[31];
      default: sign = 1'b0;
    endcase
    if (unsigned_i) sign = 1'b0;
    ext = low;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= 8 * int'(size_i)) ext[i] = sign;
    end
    data_o = shl_i ? shifted : {{XLEN{1'b0}}, ext};
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one access per handshake, word-aligned bus beats
// with byte strobes. LSU_MISALIGN_EN enables two-beat word-crossing accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                CLK,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_write_ready,
  input  logic [XLEN-1:0]     mem_read_data,
  input  logic                mem_read_data_valid,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                misalign_err
);

  localparam int B     = XLEN / 8;
  localparam int OFF_W = $clog2(B);

`ifdef LSU_MISALIGN_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  lsu_state_e        state_q;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [OFF_W-1:0]  off_q;

  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_size;
  logic [15:0]       req_mask;
  logic              req_cross;
  logic              req_bad;
  logic [ADDR_W-1:0] req_word;
  logic [2*XLEN-1:0] st_sh;
  logic [2*XLEN-1:0] ld_buf;
  logic [2*XLEN-1:0] ld_out;
  logic [XLEN-1:0]   resp_rdata_d;
  logic              beat_done;
  logic              unused_bits;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_size  = size_bytes(req_funct3);
  assign req_mask  = byte_mask(3'(req_off), req_size);
  assign req_cross = ({1'b0, 3'(req_off)} + req_size) > 4'(B);
  assign req_bad   = f3_illegal(req_funct3, req_store, XLEN == 64);
  assign req_word  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign beat_done = ((state_q == S_ACC0) || (state_q == S_ACC1)) &&
                     (store_q ? mem_write_ready : mem_read_data_valid);

  lsu_align #(.XLEN(XLEN)) u_st_align (
    .data_i     ({{XLEN{1'b0}}, req_wdata}),
    .off_i      (req_off),
    .shl_i      (1'b1),
    .size_i     (req_size),
    .unsigned_i (1'b1),
    .data_o     (st_sh)
  );

`ifdef LSU_MISALIGN_EN
  logic [XLEN-1:0] wdata_hi_q;
  logic [B-1:0]    strb_hi_q;
  logic [XLEN-1:0] rbuf_q;

  // Second-beat lanes and first-beat load bytes; pure datapath, never reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && req_valid) begin
      wdata_hi_q <= st_sh[2*XLEN-1:XLEN];
      strb_hi_q  <= req_mask[2*B-1:B];
    end
    if (state_q == S_ACC0 && beat_done) rbuf_q <= mem_read_data;
  end
`endif

  always_comb begin
    ld_buf = {{XLEN{1'b0}}, mem_read_data};
`ifdef LSU_MISALIGN_EN
    if (state_q == S_ACC1) ld_buf = {mem_read_data, rbuf_q};
`endif
  end

  lsu_align #(.XLEN(XLEN)) u_ld_align (
    .data_i     (ld_buf),
    .off_i      (off_q),
    .shl_i      (1'b0),
    .size_i     (size_bytes(f3_q)),
    .unsigned_i (f3_q[2]),
    .data_o     (ld_out)
  );

  assign resp_rdata_d = store_q ? {XLEN{1'b0}} : ld_out[XLEN-1:0];
  assign unused_bits  = ^{req_mask, st_sh, ld_out[2*XLEN-1:XLEN]};

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      req_ready    <= 1'b1;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wstrb    <= '0;
      mem_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      misalign_err <= 1'b0;
      store_q      <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            store_q   <= req_store;
            f3_q      <= req_funct3;
            off_q     <= req_off;
            if (req_bad || (req_cross && !SPLIT_EN)) begin
              // Rejected accesses never touch the bus.
              state_q      <= S_RESP;
              resp_valid   <= 1'b1;
              resp_rdata   <= '0;
              misalign_err <= 1'b1;
            end else begin
              state_q   <= S_ACC0;
              mem_en    <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= req_word;
              mem_wstrb <= req_mask[B-1:0];
              mem_wdata <= st_sh[XLEN-1:0];
            end
          end
        end
        S_ACC0: begin
          if (beat_done) begin
`ifdef LSU_MISALIGN_EN
            if (({1'b0, 3'(off_q)} + size_bytes(f3_q)) > 4'(B)) begin
              state_q   <= S_ACC1;
              mem_addr  <= mem_addr + ADDR_W'(B);
              mem_wstrb <= strb_hi_q;
              mem_wdata <= wdata_hi_q;
            end else begin
`endif
              state_q      <= S_RESP;
              mem_en       <= 1'b0;
              mem_we       <= 1'b0;
              resp_valid   <= 1'b1;
              resp_rdata   <= resp_rdata_d;
              misalign_err <= 1'b0;
`ifdef LSU_MISALIGN_EN
            end
`endif
          end
        end
`ifdef LSU_MISALIGN_EN
        S_ACC1: begin
          if (beat_done) begin
            state_q      <= S_RESP;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            resp_valid   <= 1'b1;
            resp_rdata   <= resp_rdata_d;
            misalign_err <= 1'b0;
          end
        end
`endif
        S_RESP: begin
          state_q      <= S_IDLE;
          req_ready    <= 1'b1;
          misalign_err <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
